// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: transaction controller behind a byte-level SPI slave.
// Each frame starts with a command byte (bit7 = read, low bits = start address).
// It is followed by write data bytes, or by dummy bytes that pace auto-incrementing reads.
// The controller loads the slave TX buffer with a status byte at frame start, then with read data.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   n_cs                 SPI chip select (synchronised); high ends the frame
//   start                1-cycle pulse at frame start
//   rx_data, rx_valid    received byte and its 1-cycle strobe
//   tx_data, tx_valid    byte offered to the slave TX buffer
//   tx_ready             slave TX buffer free (transfer on tx_valid & tx_ready)
//   reg_addr             register address for the current access
//   reg_wdata, reg_wr    write data and 1-cycle write strobe
//   reg_rd               1-cycle read strobe
//   reg_rdata, reg_rvalid read data and its valid strobe
//   busy                 controller not idle
//   err_timeout          sticky read-timeout flag, cleared by start
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter int unsigned RD_TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              n_cs,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rvalid,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RD_OFFER
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [7:0]        tx_data_nxt;
  logic              tx_valid_nxt;
  logic [ADDR_W-1:0] reg_addr_nxt;
  logic [7:0]        reg_wdata_nxt;
  logic              reg_wr_nxt;
  logic              reg_rd_nxt;
  logic              busy_nxt;
  logic              err_timeout_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tx_data     <= tx_data_nxt;
      tx_valid    <= tx_valid_nxt;
      reg_addr    <= reg_addr_nxt;
      reg_wdata   <= reg_wdata_nxt;
      reg_wr      <= reg_wr_nxt;
      reg_rd      <= reg_rd_nxt;
      busy        <= busy_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    tx_data_nxt     = tx_data;
    // An offered byte is held until the slave takes it
    tx_valid_nxt    = tx_valid & ~tx_ready;
    // The address moves on the cycle after each write strobe
    reg_addr_nxt    = reg_wr ? reg_addr + ADDR_W'(1) : reg_addr;
    reg_wdata_nxt   = reg_wdata;
    reg_wr_nxt      = 1'b0;
    reg_rd_nxt      = 1'b0;
    err_timeout_nxt = err_timeout;

    if (start) begin
      err_timeout_nxt = 1'b0;
      tx_data_nxt     = STATUS_BYTE;
      tx_valid_nxt    = 1'b1;
      state_nxt       = CMD;
    end else if ((state != IDLE) && n_cs) begin
      // Frame ended by the master; any outstanding read is abandoned
      tx_valid_nxt = 1'b0;
      state_nxt    = IDLE;
    end else begin
      case (state)
        CMD: begin
          if (rx_valid) begin
            reg_addr_nxt = rx_data[ADDR_W-1:0];
            if (rx_data[7]) begin
              reg_rd_nxt = 1'b1;
              state_nxt  = RD_REQ;
            end else begin
              state_nxt  = WRITE;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            reg_wdata_nxt = rx_data;
            reg_wr_nxt    = 1'b1;
          end
        end
        RD_REQ: begin
          // reg_rd is high during this state; start timing the response
          cnt_nxt   = '0;
          state_nxt = RD_WAIT;
        end
        RD_WAIT: begin
          if (reg_rvalid) begin
            tx_data_nxt  = reg_rdata;
            tx_valid_nxt = 1'b1;
            state_nxt    = RD_OFFER;
          end else if (cnt == CNT_LAST) begin
            tx_data_nxt     = TIMEOUT_BYTE;
            tx_valid_nxt    = 1'b1;
            err_timeout_nxt = 1'b1;
            state_nxt       = RD_OFFER;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RD_OFFER: begin
          // Next byte clocked by the master; only move on once the offer is taken
          if (rx_valid && (!tx_valid || tx_ready)) begin
            reg_addr_nxt = reg_addr + ADDR_W'(1);
            reg_rd_nxt   = 1'b1;
            state_nxt    = RD_REQ;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: randomized frames checked against a transaction-level model
// (expected write list, expected read address list, expected TX byte stream).
module tb_spi_reg_ctrl;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned RD_TIMEOUT = 8;
  localparam logic [7:0]  STATUS     = 8'hA5;
  localparam int          GAP        = 16;

  logic        clk;
  logic        n_rst;
  logic        n_cs;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_rdata;
  logic        reg_rvalid;
  logic        busy;
  logic        err_timeout;

  spi_reg_ctrl #(
    .ADDR_W     (ADDR_W),
    .STATUS_BYTE(STATUS),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .n_cs       (n_cs),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register file contents and expected transactions
  logic [7:0]  mem [128];
  logic [14:0] exp_wr[$];   // {addr, data}
  logic [6:0]  exp_rd[$];
  int          dly_q[$];    // response delay per read, 0 = never respond
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  plan_wd[$];
  int          plan_dly[$];

  // Monitor and register-file responder, sampled mid-cycle after input updates
  initial begin : mon
    int         cd;
    logic [7:0] rsp;
    logic [14:0] ew;
    logic [6:0]  er;
    cd  = 0;
    rsp = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      reg_rvalid = 1'b0;
      if (!n_rst || n_cs) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          reg_rvalid = 1'b1;
          reg_rdata  = rsp;
        end
      end
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (reg_wr) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'(reg_wr), 32'd0);
        end else begin
          ew = exp_wr.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(ew[14:8]));
          check("wr_data", 32'(reg_wdata), 32'(ew[7:0]));
        end
      end
      if (reg_rd) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", 32'(reg_rd), 32'd0);
        end else begin
          er = exp_rd.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(er));
          rsp = mem[er];
          cd  = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_gap();
    for (int i = 0; i < GAP; i++) begin
      tick();
      rx_valid = 1'b0;
      tx_ready = (i >= GAP - 3) ? 1'b1 : 1'($urandom % 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tx_ready = 1'($urandom % 2);
    idle_gap();
  endtask

  task automatic run_frame(input bit rd, input logic [6:0] a, input int n);
    logic [6:0] p;
    logic [7:0] d;
    logic [7:0] wq[$];
    int         k;
    bit         err_e;
    exp_tx.delete();
    got_tx.delete();
    exp_tx.push_back(STATUS);
    err_e = 1'b0;
    p     = a;
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        d = (plan_wd.size() != 0) ? plan_wd.pop_front() : 8'($urandom);
        wq.push_back(d);
        exp_wr.push_back({p, d});
        mem[p] = d;
        p = p + 7'd1;
      end
    end else begin
      // n dummy bytes after the command trigger n+1 reads
      for (int i = 0; i <= n; i++) begin
        if (plan_dly.size() != 0) k = plan_dly.pop_front();
        else k = (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, RD_TIMEOUT));
        exp_rd.push_back(p);
        dly_q.push_back(k);
        exp_tx.push_back((k == 0) ? 8'hFF : mem[p]);
        if (k == 0) err_e = 1'b1;
        p = p + 7'd1;
      end
    end
    tick();
    n_cs     = 1'b0;
    start    = 1'b1;
    tx_ready = 1'b0;
    tick();
    start = 1'b0;
    check("start_tx_data", 32'(tx_data), 32'(STATUS));
    check("start_tx_valid", 32'(tx_valid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_err_clr", 32'(err_timeout), 32'd0);
    idle_gap();
    send_byte({rd, a});
    for (int i = 0; i < n; i++) send_byte(rd ? 8'($urandom) : wq[i]);
    check("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check("tx_byte", 32'(got_tx[i]), 32'(exp_tx[i]));
    check("wr_missing", 32'(exp_wr.size()), 32'd0);
    check("rd_missing", 32'(exp_rd.size()), 32'd0);
    check("err_timeout", 32'(err_timeout), 32'(err_e));
    tick();
    n_cs = 1'b1;
    tick();
    check("end_busy", 32'(busy), 32'd0);
    check("end_tx_valid", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    n_rst     = 1'b0;
    n_cs      = 1'b1;
    start     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    reg_rdata = 8'h00;
    reg_rvalid = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    n_rst = 1'b1;
    tick();

    // rx_valid while idle has no effect
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("idle_rx_busy", 32'(busy), 32'd0);
    tick();
    check("idle_rx_wr", 32'(reg_wr), 32'd0);

    // Directed: write, read with 2-cycle response, address wrap, late-as-possible response
    plan_wd.push_back(8'h11);
    plan_wd.push_back(8'h22);
    run_frame(1'b0, 7'h05, 2);
    plan_wd.push_back(8'h3C);
    run_frame(1'b0, 7'h07, 1);
    plan_dly.push_back(2);
    plan_dly.push_back(3);
    run_frame(1'b1, 7'h07, 1);
    run_frame(1'b0, 7'h7F, 2);
    plan_dly.push_back(RD_TIMEOUT);
    plan_dly.push_back(1);
    run_frame(1'b1, 7'h7F, 1);

    // Directed timeout: FF and err_timeout appear RD_TIMEOUT+2 edges after the command byte
    exp_rd.push_back(7'h10);
    dly_q.push_back(0);
    tick();
    n_cs     = 1'b0;
    start    = 1'b1;
    tx_ready = 1'b1;
    tick();
    start = 1'b0;
    idle_gap();
    tick();
    rx_data  = 8'h90;
    rx_valid = 1'b1;
    for (int i = 1; i <= RD_TIMEOUT + 1; i++) begin
      tick();
      rx_valid = 1'b0;
      tx_ready = 1'b0;
    end
    check("to_err_early", 32'(err_timeout), 32'd0);
    check("to_valid_early", 32'(tx_valid), 32'd0);
    tick();
    check("to_tx_data", 32'(tx_data), 32'hFF);
    check("to_tx_valid", 32'(tx_valid), 32'd1);
    check("to_err", 32'(err_timeout), 32'd1);
    tick();
    check("to_hold", 32'(tx_valid), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_err_clr", 32'(err_timeout), 32'd0);
    check("to_restart_tx", 32'(tx_data), 32'(STATUS));

    // Abort mid-read by raising n_cs: back to idle with the offer withdrawn
    exp_rd.push_back(7'h11);
    dly_q.push_back(0);
    rx_data  = 8'h91;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    n_cs = 1'b1;
    tick();
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (RD_TIMEOUT + 2) tick();
    check("abort_err", 32'(err_timeout), 32'd0);

    // Reset in the middle of a read wait
    exp_rd.push_back(7'h12);
    dly_q.push_back(0);
    n_cs     = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    idle_gap();
    tick();
    rx_data  = 8'h92;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    check("rst_mid_addr", 32'(reg_addr), 32'd0);
    check("rst_mid_wdata", 32'(reg_wdata), 32'd0);
    check("rst_mid_rd", 32'(reg_rd), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_rd.delete();
    dly_q.delete();
    n_cs = 1'b1;
    tick();
    n_rst = 1'b1;
    tick();

    // Randomized frames
    for (int f = 0; f < 25; f++)
      run_frame(1'($urandom % 2), 7'($urandom), int'($urandom_range(1, 4)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
